// File: rtl/result_accumulator.sv
// Element-wise accumulator for systolic multiplier result blocks: sums NUM_TILES
// partial blocks, then streams the finished tile out row-major over valid/ready.
module result_accumulator #(
   parameter int DATA_W    = 16,
   parameter int ROWS      = 2,
   parameter int COLS      = 2,
   parameter int NUM_TILES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          done_in,
   input  logic [ROWS*COLS*DATA_W-1:0]   block_in,
   output logic                          acc_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_last,
   output logic [7:0]                    tile_cnt,
   output logic                          overflow,
   output logic                          err_drop
);

   localparam int N     = ROWS * COLS;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t               state, state_next;
   logic [DATA_W-1:0]    acc [N];
   logic [DATA_W:0]      sum [N];
   logic                 done_prev;
   logic [IDX_W-1:0]     out_idx;
   logic                 capture, xfer, last_xfer, tile_full, any_carry;

   // Capture is a rising edge of the level done flag; sums keep the carry bit
   always_comb begin
      capture   = done_in & ~done_prev;
      xfer      = (state == DRAIN) & out_ready;
      last_xfer = xfer && (out_idx == IDX_W'(N - 1));
      tile_full = ((tile_cnt + 8'd1) == 8'(NUM_TILES));
      any_carry = 1'b0;
      for (int e = 0; e < N; e++) begin
         sum[e]    = {1'b0, acc[e]} + {1'b0, block_in[e*DATA_W +: DATA_W]};
         any_carry = any_carry | sum[e][DATA_W];
      end
   end

   always_comb begin
      state_next = state;
      acc_ready  = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_last   = 1'b0;
      case (state)
         ACCUM: begin
            acc_ready = 1'b1;
            if (capture && tile_full)
               state_next = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_data  = acc[out_idx];
            out_last  = (out_idx == IDX_W'(N - 1));
            if (last_xfer)
               state_next = ACCUM;
         end
         default: state_next = ACCUM;
      endcase
      if (clear)
         state_next = ACCUM;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ACCUM;
      else
         state <= state_next;
   end

   // Captures arriving outside ACCUM never touch the sums; they only flag err_drop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < N; e++)
            acc[e] <= '0;
         done_prev <= 1'b0;
         tile_cnt  <= '0;
         out_idx   <= '0;
         overflow  <= 1'b0;
         err_drop  <= 1'b0;
      end else begin
         done_prev <= done_in;
         if (clear) begin
            for (int e = 0; e < N; e++)
               acc[e] <= '0;
            tile_cnt <= '0;
            out_idx  <= '0;
            overflow <= 1'b0;
            err_drop <= 1'b0;
         end else begin
            case (state)
               ACCUM: begin
                  if (capture) begin
                     for (int e = 0; e < N; e++)
                        acc[e] <= sum[e][DATA_W-1:0];
                     if (any_carry)
                        overflow <= 1'b1;
                     tile_cnt <= tile_cnt + 8'd1;
                  end
               end
               DRAIN: begin
                  if (capture)
                     err_drop <= 1'b1;
                  if (last_xfer) begin
                     for (int e = 0; e < N; e++)
                        acc[e] <= '0;
                     tile_cnt <= '0;
                     out_idx  <= '0;
                  end else if (xfer) begin
                     out_idx <= out_idx + IDX_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_result_accumulator.sv
// Self-checking bench for result_accumulator: directed and randomized tiles checked
// against an arithmetic model of the summed blocks, flags and tile progress.
module tb_result_accumulator;

   localparam int TILES = 2;

   logic        clk;
   logic        rst;
   logic        clear;
   logic        done_in;
   logic [63:0] block_in;
   logic        acc_ready;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic [7:0]  tile_cnt;
   logic        overflow;
   logic        err_drop;

   // Second instance exercises the single-tile configuration
   logic        clear1;
   logic        done1;
   logic [63:0] block1;
   logic        acc_ready1;
   logic        out_valid1;
   logic        out_ready1;
   logic [15:0] out_data1;
   logic        out_last1;
   logic [7:0]  tile_cnt1;
   logic        overflow1;
   logic        err_drop1;

   int tests_run;
   int tests_failed;

   logic [15:0] m_acc [4];
   int          m_tiles;
   logic        m_ovf;
   logic        m_err;

   result_accumulator #(.DATA_W(16), .ROWS(2), .COLS(2), .NUM_TILES(TILES)) dut (
      .clk(clk), .rst(rst), .clear(clear), .done_in(done_in), .block_in(block_in),
      .acc_ready(acc_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .tile_cnt(tile_cnt),
      .overflow(overflow), .err_drop(err_drop)
   );

   result_accumulator #(.DATA_W(16), .ROWS(2), .COLS(2), .NUM_TILES(1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear1), .done_in(done1), .block_in(block1),
      .acc_ready(acc_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_data(out_data1), .out_last(out_last1), .tile_cnt(tile_cnt1),
      .overflow(overflow1), .err_drop(err_drop1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [15:0] d);
      return {d, c, b, a};
   endfunction

   task automatic model_reset_tile();
      for (int e = 0; e < 4; e++) m_acc[e] = 16'h0;
      m_tiles = 0;
   endtask

   // A capture while the tile is full (draining) is dropped and flagged
   task automatic model_capture(input logic [63:0] b);
      int s;
      if (m_tiles == TILES) begin
         m_err = 1'b1;
      end else begin
         for (int e = 0; e < 4; e++) begin
            s = int'(m_acc[e]) + int'(b[e*16 +: 16]);
            if (s > 65535) m_ovf = 1'b1;
            m_acc[e] = 16'(s);
         end
         m_tiles++;
      end
   endtask

   task automatic check_status(input string tag);
      check_output({tag, "_tile_cnt"}, tile_cnt, m_tiles);
      check_output({tag, "_acc_ready"}, acc_ready, m_tiles != TILES);
      check_output({tag, "_out_valid"}, out_valid, m_tiles == TILES);
      check_output({tag, "_overflow"}, overflow, m_ovf);
      check_output({tag, "_err_drop"}, err_drop, m_err);
   endtask

   // One-cycle done pulse, status check, then one idle cycle so done_prev falls
   task automatic apply_stimulus(input logic [63:0] b, input string tag);
      done_in  = 1'b1;
      block_in = b;
      @(negedge clk);
      done_in = 1'b0;
      model_capture(b);
      check_status(tag);
      @(negedge clk);
   endtask

   task automatic drain_tile(input logic [31:0] pat, input string tag);
      int   idx;
      int   cyc;
      logic r;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 64) begin
         r = (cyc >= 32) ? 1'b1 : pat[cyc];
         out_ready = r;
         check_output({tag, "_valid"}, out_valid, 1);
         check_output({tag, "_data"}, out_data, m_acc[idx]);
         check_output({tag, "_last"}, out_last, idx == 3);
         @(negedge clk);
         if (r) idx++;
         cyc++;
      end
      out_ready = 1'b0;
      check_output({tag, "_drained"}, idx, 4);
      if (pat == 32'hFFFF_FFFF)
         check_output({tag, "_cycles"}, cyc, 4);
      model_reset_tile();
      check_output({tag, "_post_valid"}, out_valid, 0);
      check_output({tag, "_post_ready"}, acc_ready, 1);
      check_output({tag, "_post_tile_cnt"}, tile_cnt, 0);
   endtask

   initial begin
      logic [63:0] b1;
      logic [63:0] b2;
      tests_run    = 0;
      tests_failed = 0;
      m_ovf        = 1'b0;
      m_err        = 1'b0;
      model_reset_tile();
      rst = 1'b1; clear = 1'b0; done_in = 1'b0; block_in = '0; out_ready = 1'b0;
      clear1 = 1'b0; done1 = 1'b0; block1 = '0; out_ready1 = 1'b1;

      #1;
      check_status("reset");
      check_output("reset_out_data", out_data, 0);
      check_output("reset_out_last", out_last, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Two-tile sum streamed at full throughput
      apply_stimulus(mk(1, 2, 3, 4), "basic_a");
      apply_stimulus(mk(5, 6, 7, 8), "basic_b");
      drain_tile(32'hFFFF_FFFF, "basic_drain");

      // Single-tile instance drains straight after one capture
      done1  = 1'b1;
      block1 = mk(10, 20, 30, 40);
      @(negedge clk);
      done1 = 1'b0;
      check_output("nt1_tile_cnt", tile_cnt1, 1);
      check_output("nt1_ready", acc_ready1, 0);
      for (int k = 0; k < 4; k++) begin
         check_output("nt1_valid", out_valid1, 1);
         check_output("nt1_data", out_data1, 16'(10 * (k + 1)));
         check_output("nt1_last", out_last1, k == 3);
         @(negedge clk);
      end
      check_output("nt1_post_valid", out_valid1, 0);
      check_output("nt1_post_tile_cnt", tile_cnt1, 0);
      check_output("nt1_err_drop", err_drop1, 0);
      check_output("nt1_overflow", overflow1, 0);

      // done_in held high for six cycles counts once
      done_in  = 1'b1;
      block_in = mk(3, 3, 3, 3);
      repeat (6) @(negedge clk);
      done_in = 1'b0;
      model_capture(mk(3, 3, 3, 3));
      check_status("held");
      @(negedge clk);
      apply_stimulus(mk(3, 5, 7, 9), "held_b");
      drain_tile(32'h0000_0069, "backpressure");

      // Capture during DRAIN is dropped and flagged
      apply_stimulus(mk(1, 1, 1, 1), "drop_a");
      apply_stimulus(mk(2, 2, 2, 2), "drop_b");
      apply_stimulus(mk(9, 9, 9, 9), "drop_c");
      drain_tile(32'hFFFF_FFFF, "drop_drain");
      apply_stimulus(mk(1, 2, 3, 4), "fresh_a");
      apply_stimulus(mk(0, 0, 0, 0), "fresh_b");
      drain_tile(32'hFFFF_FFFF, "fresh_drain");

      // Wraparound and sticky overflow, then clear with a coincident capture
      apply_stimulus(mk(16'hFFFF, 0, 0, 0), "ovf_a");
      apply_stimulus(mk(16'h0002, 0, 0, 0), "ovf_b");
      drain_tile(32'hFFFF_FFFF, "ovf_drain");
      check_output("ovf_sticky", overflow, 1);
      clear    = 1'b1;
      done_in  = 1'b1;
      block_in = mk(7, 7, 7, 7);
      @(negedge clk);
      clear   = 1'b0;
      done_in = 1'b0;
      model_reset_tile();
      m_ovf = 1'b0;
      m_err = 1'b0;
      check_status("clear");
      @(negedge clk);

      // Randomized tiles with random backpressure
      for (int t = 0; t < 6; t++) begin
         b1 = {$urandom, $urandom};
         b2 = {$urandom, $urandom};
         apply_stimulus(b1, "rand_a");
         apply_stimulus(b2, "rand_b");
         drain_tile($urandom | 32'h1, "rand_drain");
      end

      // Async reset after two elements leave, with done_in high across release
      apply_stimulus({$urandom, $urandom}, "arst_a");
      apply_stimulus({$urandom, $urandom}, "arst_b");
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check_output("arst_pre_data", out_data, m_acc[k]);
         @(negedge clk);
      end
      out_ready = 1'b0;
      #2;
      rst      = 1'b1;
      done_in  = 1'b1;
      b1       = {$urandom, $urandom};
      block_in = b1;
      #1;
      model_reset_tile();
      m_ovf = 1'b0;
      m_err = 1'b0;
      check_status("arst");
      check_output("arst_out_data", out_data, 0);
      check_output("arst_out_last", out_last, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      done_in = 1'b0;
      model_capture(b1);
      check_status("release_capture");
      @(negedge clk);
      apply_stimulus({$urandom, $urandom}, "arst_c");
      drain_tile(32'hFFFF_FFFF, "arst_drain");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
